// File: rtl/dmi_tl_pkg.sv
// Shared types and encodings for the DMI-to-TileLink-UL bridge.
package dmi_tl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_A_SEND,
    ST_D_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmi_tl_bridge.sv
// DMI request/response to single-beat TileLink-UL bridge, one transaction outstanding.
// Optional D-channel timeout with late-beat drain: define DMI_TL_TIMEOUT_EN.
module dmi_tl_bridge
  import dmi_tl_pkg::*;
#(
  parameter int unsigned ABITS       = 7,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NOP_ADDR    = 'h40,
  parameter int unsigned SOURCE_ID   = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dmi_req_valid,
  output logic                  dmi_req_ready,
  input  logic [1:0]            dmi_req_op,
  input  logic [ABITS-1:0]      dmi_req_addr,
  input  logic [DATA_W-1:0]     dmi_req_data,
  output logic                  dmi_resp_valid,
  input  logic                  dmi_resp_ready,
  output logic [1:0]            dmi_resp_resp,
  output logic [DATA_W-1:0]     dmi_resp_data,
  output logic                  tl_a_valid,
  input  logic                  tl_a_ready,
  output logic [2:0]            tl_a_opcode,
  output logic [2:0]            tl_a_size,
  output logic                  tl_a_source,
  output logic [ABITS+1:0]      tl_a_address,
  output logic [DATA_W/8-1:0]   tl_a_mask,
  output logic [DATA_W-1:0]     tl_a_data,
  input  logic                  tl_d_valid,
  output logic                  tl_d_ready,
  input  logic                  tl_d_denied,
  input  logic                  tl_d_corrupt,
  input  logic [DATA_W-1:0]     tl_d_data
);

  localparam int unsigned AW = ABITS + 2;
  localparam int unsigned MW = DATA_W / 8;
  localparam logic [AW-1:0] NOP_A = AW'(NOP_ADDR);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e              state_q, state_d;
  dmi_op_e             op_q, op_d;
  logic                req_ready_q, req_ready_d;
  logic                a_valid_q, a_valid_d;
  logic                d_ready_q, d_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [2:0]          a_opcode_q, a_opcode_d;
  logic [AW-1:0]       a_addr_q, a_addr_d;
  logic [MW-1:0]       a_mask_q, a_mask_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                drain_nx;

`ifdef DMI_TL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drain_q, drain_d;
`endif

  logic req_fire, a_fire, d_fire;
  assign req_fire = dmi_req_valid & req_ready_q;
  assign a_fire   = a_valid_q & tl_a_ready;
  assign d_fire   = tl_d_valid & d_ready_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_opcode_d = a_opcode_q;
    a_addr_d   = a_addr_q;
    a_mask_d   = a_mask_q;
    a_data_d   = a_data_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
`ifdef DMI_TL_TIMEOUT_EN
    cnt_d   = '0;
    drain_d = drain_q;
    if (drain_q && d_fire) drain_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_d     = dmi_op_e'(dmi_req_op);
          resp_d   = RESP_OK;
          rdata_d  = '0;
          a_data_d = '0;
          a_mask_d = '1;
          a_addr_d = {dmi_req_addr, 2'b00};
          state_d  = ST_A_SEND;
          case (dmi_op_e'(dmi_req_op))
            OP_READ:  a_opcode_d = TL_GET;
            OP_WRITE: begin
              a_opcode_d = TL_PUT_FULL;
              a_data_d   = dmi_req_data;
            end
            OP_NOP: begin
              a_opcode_d = TL_PUT_PARTIAL;
              a_mask_d   = '0;
              a_addr_d   = NOP_A;
            end
            default: begin
              resp_d  = RESP_FAIL;
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_A_SEND: if (a_fire) state_d = ST_D_WAIT;
      ST_D_WAIT: begin
        if (d_fire) begin
          resp_d  = (tl_d_denied || tl_d_corrupt) ? RESP_FAIL : RESP_OK;
          rdata_d = (op_q == OP_READ && !tl_d_denied) ? tl_d_data : '0;
          state_d = ST_RESP;
        end
`ifdef DMI_TL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_d  = RESP_BUSY;
          rdata_d = '0;
          drain_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: if (dmi_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef DMI_TL_TIMEOUT_EN
    drain_nx = drain_d;
`else
    drain_nx = 1'b0;
`endif
    // Handshake outputs are registered from the next state so they align with it.
    req_ready_d  = (state_d == ST_IDLE);
    a_valid_d    = (state_d == ST_A_SEND) && !drain_nx;
    d_ready_d    = (state_d == ST_D_WAIT) || drain_nx;
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      req_ready_q  <= 1'b1;
      a_valid_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      a_opcode_q   <= '0;
      a_addr_q     <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
`ifdef DMI_TL_TIMEOUT_EN
      cnt_q        <= '0;
      drain_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      req_ready_q  <= req_ready_d;
      a_valid_q    <= a_valid_d;
      d_ready_q    <= d_ready_d;
      resp_valid_q <= resp_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_addr_q     <= a_addr_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
`ifdef DMI_TL_TIMEOUT_EN
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
`endif
    end
  end

  assign dmi_req_ready  = req_ready_q;
  assign dmi_resp_valid = resp_valid_q;
  assign dmi_resp_resp  = resp_q;
  assign dmi_resp_data  = rdata_q;
  assign tl_a_valid     = a_valid_q;
  assign tl_a_opcode    = a_opcode_q;
  assign tl_a_size      = 3'($clog2(MW));
  assign tl_a_source    = 1'(SOURCE_ID);
  assign tl_a_address   = a_addr_q;
  assign tl_a_mask      = a_mask_q;
  assign tl_a_data      = a_data_q;
  assign tl_d_ready     = d_ready_q;

endmodule

// File: tb/tb_dmi_tl_bridge.sv
// Scoreboard bench for dmi_tl_bridge: expected A beats and DMI responses are queued at issue time.
module tb_dmi_tl_bridge;

`ifdef DMI_TL_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [1:0]  dmi_req_op;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [1:0]  dmi_resp_resp;
  logic [31:0] dmi_resp_data;
  logic        tl_a_valid;
  logic        tl_a_ready;
  logic [2:0]  tl_a_opcode;
  logic [2:0]  tl_a_size;
  logic        tl_a_source;
  logic [8:0]  tl_a_address;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_data;
  logic        tl_d_valid;
  logic        tl_d_ready;
  logic        tl_d_denied;
  logic        tl_d_corrupt;
  logic [31:0] tl_d_data;

  dmi_tl_bridge #(
    .ABITS(7), .DATA_W(32), .NOP_ADDR('h40), .SOURCE_ID(0), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_size(tl_a_size), .tl_a_source(tl_a_source), .tl_a_address(tl_a_address),
    .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_denied(tl_d_denied),
    .tl_d_corrupt(tl_d_corrupt), .tl_d_data(tl_d_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; bit denied; bit corrupt; int delay; bit skip; } dplan_t;
  typedef struct { logic [2:0] opc; logic [8:0] addr; logic [3:0] mask; logic [31:0] data; } aexp_t;
  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;

  aexp_t  exp_a[$];
  dplan_t plan_q[$];
  dplan_t d_q[$];
  rexp_t  exp_r[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_en   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the bridge must put on A and return on DMI for one request.
  task automatic issue(input int op, input logic [6:0] a, input logic [31:0] wd,
                       input dplan_t p, input bit expect_resp);
    aexp_t ea;
    rexp_t er;
    bit    fired = 0;
    if (op != 3) begin
      ea.addr = (op == 0) ? 9'h40 : 9'(a * 4);
      ea.opc  = (op == 1) ? 3'd4 : (op == 2) ? 3'd0 : 3'd1;
      ea.mask = (op == 0) ? 4'h0 : 4'hF;
      ea.data = (op == 2) ? wd : 32'h0;
      exp_a.push_back(ea);
      plan_q.push_back(p);
      er.resp = (p.denied || p.corrupt) ? 2'd2 : 2'd0;
      er.data = (op == 1 && !p.denied) ? p.data : 32'h0;
    end else begin
      er.resp = 2'd2;
      er.data = 32'h0;
    end
    if (expect_resp) exp_r.push_back(er);
    dmi_req_valid = 1'b1;
    dmi_req_op    = 2'(op);
    dmi_req_addr  = a;
    dmi_req_data  = wd;
    for (int i = 0; i < 300 && !fired; i++) begin
      @(negedge clock);
      if (dmi_req_ready) fired = 1;
      @(posedge clock); #1;
    end
    dmi_req_valid = 1'b0;
    dmi_req_op    = $urandom_range(0, 3);
    dmi_req_data  = $urandom;
    if (!fired) check("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_resp_lat(input string name, input int exp_lat);
    int k = 0;
    bit seen = 0;
    while (k < 100 && !seen) begin
      @(negedge clock);
      k++;
      if (dmi_resp_valid) seen = 1;
    end
    check(name, 64'(k), 64'(exp_lat));
    @(posedge clock); #1;
  endtask

  function automatic dplan_t mk_plan(input logic [31:0] d, input bit den, input bit cor,
                                     input int dly, input bit skip);
    dplan_t p;
    p.data = d; p.denied = den; p.corrupt = cor; p.delay = dly; p.skip = skip;
    return p;
  endfunction

  // Monitor: A-channel and response scoreboard plus stability/ready invariants.
  initial begin
    bit    a_hold = 0, r_hold = 0;
    logic [47:0] a_snap;
    logic [33:0] r_snap;
    aexp_t ea;
    rexp_t er;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        a_hold = 0; r_hold = 0;
      end else begin
        if (a_hold) check("a_stable", {tl_a_valid, tl_a_opcode, tl_a_address, tl_a_mask, tl_a_data},
                          {1'b1, a_snap[47:0]});
        if (r_hold) check("resp_stable", {dmi_resp_valid, dmi_resp_resp, dmi_resp_data},
                          {1'b1, r_snap});
        if (tl_a_valid || dmi_resp_valid) check("req_ready_busy", 64'(dmi_req_ready), 0);
        if (tl_a_valid && tl_a_ready) begin
          if (exp_a.size() == 0) check("a_unexpected", 1, 0);
          else begin
            ea = exp_a.pop_front();
            check("a_opcode", 64'(tl_a_opcode), 64'(ea.opc));
            check("a_address", 64'(tl_a_address), 64'(ea.addr));
            check("a_mask", 64'(tl_a_mask), 64'(ea.mask));
            check("a_data", 64'(tl_a_data), 64'(ea.data));
            check("a_size_source", {tl_a_size, tl_a_source}, {3'd2, 1'b0});
            d_q.push_back(plan_q.pop_front());
          end
        end
        if (dmi_resp_valid && dmi_resp_ready) begin
          if (exp_r.size() == 0) check("resp_unexpected", 1, 0);
          else begin
            er = exp_r.pop_front();
            check("resp_code", 64'(dmi_resp_resp), 64'(er.resp));
            check("resp_data", 64'(dmi_resp_data), 64'(er.data));
          end
        end
        a_hold = tl_a_valid && !tl_a_ready;
        a_snap = {tl_a_opcode, tl_a_address, tl_a_mask, tl_a_data};
        r_hold = dmi_resp_valid && !dmi_resp_ready;
        r_snap = {dmi_resp_resp, dmi_resp_data};
      end
    end
  end

  // TL slave: answers each accepted A beat with its pre-planned D beat.
  initial begin
    dplan_t p;
    bit got;
    tl_d_valid = 0; tl_d_denied = 0; tl_d_corrupt = 0; tl_d_data = '0;
    forever begin
      @(posedge clock); #1;
      if (d_q.size() != 0) begin
        p = d_q.pop_front();
        if (!p.skip) begin
          repeat (p.delay) begin @(posedge clock); #1; end
          tl_d_valid = 1; tl_d_data = p.data; tl_d_denied = p.denied; tl_d_corrupt = p.corrupt;
          got = 0;
          for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (tl_d_ready) got = 1;
            @(posedge clock); #1;
          end
          tl_d_valid = 0; tl_d_denied = 0; tl_d_corrupt = 0; tl_d_data = $urandom;
          if (!got) check("d_accept_timeout", 0, 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      if (rnd_en) begin
        tl_a_ready     = $urandom_range(0, 1);
        dmi_resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    int op;
    reset_n = 0; dmi_req_valid = 0; dmi_req_op = 0; dmi_req_addr = 0; dmi_req_data = 0;
    tl_a_ready = 1; dmi_resp_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {dmi_req_ready, tl_a_valid, tl_d_ready, dmi_resp_valid},
          {1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_regs", {dmi_resp_resp, dmi_resp_data, tl_a_data}, '0);
    reset_n = 1;
    @(posedge clock); #1;

    issue(1, 7'h11, 32'h0, mk_plan(32'hDEADBEEF, 0, 0, 0, 0), 1);
    wait_resp_lat("read_latency", 3);
    issue(2, 7'h10, 32'h1, mk_plan(32'h5555AAAA, 0, 0, 0, 0), 1);
    wait_resp_lat("write_latency", 3);
    issue(0, 7'h33, 32'hFFFF, mk_plan(32'h12345678, 0, 0, 1, 0), 1);
    wait_resp_lat("nop_latency", 4);
    issue(3, 7'h05, 32'hCAFE, mk_plan(0, 0, 0, 0, 0), 1);
    wait_resp_lat("rsvd_latency", 1);

    // Backpressure on A for 5 cycles and on the response for 3 cycles.
    tl_a_ready = 0; dmi_resp_ready = 0;
    issue(2, 7'h10, 32'h1, mk_plan(32'h0, 0, 0, 0, 0), 1);
    repeat (5) begin
      @(negedge clock);
      check("a_valid_held", 64'(tl_a_valid), 1);
    end
    @(posedge clock); #1;
    tl_a_ready = 1;
    wait_resp_lat("stalled_resp", 3);
    repeat (3) begin
      @(negedge clock);
      check("resp_valid_held", 64'(dmi_resp_valid), 1);
    end
    @(posedge clock); #1;
    dmi_resp_ready = 1;
    @(posedge clock); #1;

    issue(1, 7'h22, 32'h0, mk_plan(32'hA5A5A5A5, 1, 0, 0, 0), 1);
    wait_resp_lat("denied_latency", 3);
    issue(1, 7'h23, 32'h0, mk_plan(32'h0F0F0F0F, 0, 1, 2, 0), 1);
    wait_resp_lat("corrupt_latency", 5);

    // Reset while waiting on D: the transaction is abandoned.
    issue(1, 7'h44, 32'h0, mk_plan(32'h0, 0, 0, 0, 1), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("in_d_wait", {tl_d_ready, tl_a_valid}, {1'b1, 1'b0});
    @(posedge clock); #1;
    reset_n = 0;
    @(posedge clock); #1;
    check("mid_reset_outputs", {dmi_req_ready, tl_a_valid, tl_d_ready, dmi_resp_valid},
          {1'b1, 1'b0, 1'b0, 1'b0});
    reset_n = 1;
    @(posedge clock); #1;

`ifdef DMI_TL_TIMEOUT_EN
    issue(1, 7'h12, 32'h0, mk_plan(32'h0, 0, 0, 0, 1), 0);
    exp_r.push_back('{resp: 2'd3, data: 32'h0});
    wait_resp_lat("timeout_latency", 10);
    @(negedge clock);
    check("drain_ready", 64'(tl_d_ready), 1);
    @(posedge clock); #1;
    tl_d_valid = 1; tl_d_data = 32'hBADBAD00;
    @(posedge clock); #1;
    tl_d_valid = 0;
    @(negedge clock);
    check("drain_cleared", 64'(tl_d_ready), 0);
    @(posedge clock); #1;
    issue(1, 7'h13, 32'h0, mk_plan(32'h600DF00D, 0, 0, 0, 0), 1);
    wait_resp_lat("post_timeout_read", 3);
`endif

    rnd_en = 1;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      issue(op, 7'($urandom), $urandom,
            mk_plan($urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    $urandom_range(0, 3), 0), 1);
    end
    for (int i = 0; i < 500 && exp_r.size() != 0; i++) @(posedge clock);
    rnd_en = 0;
    check("resp_queue_drained", 64'(exp_r.size()), 0);
    check("a_queue_drained", 64'(exp_a.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
